lsu_mem_stage: RTL and testbench

- Load/store unit directly downstream of the execute ALU.
- Takes the ALU-computed effective address (ALU_ADD result), the store data and the access width, and runs one aligned 64-bit memory transaction per instruction over a valid/ready request channel.
- Extracts the addressed byte lane and sign/zero-extends load data, then delivers a single-cycle writeback pulse to the register-file stage.
- Non-pipelined: one outstanding access at a time.

---
 rtl/lsu_mem_stage_if.sv | 24 ++
 rtl/lsu_mem_stage.sv | 153 +++++++++++++++
 tb/tb_lsu_mem_stage.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_stage_if.sv
// rtl/lsu_mem_stage_if.sv - memory-side request/response bus of the load/store unit
interface lsu_mem_stage_if #(
    parameter int ARCH_WIDTH = 64,
    parameter int STRB_WIDTH = ARCH_WIDTH / 8
);
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_we;
    logic [ARCH_WIDTH-1:0] mem_addr;
    logic [ARCH_WIDTH-1:0] mem_wdata;
    logic [STRB_WIDTH-1:0] mem_wstrb;
    logic                  mem_resp_valid;
    logic [ARCH_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - non-pipelined load/store unit: one aligned doubleword access per op
module lsu_mem_stage #(
    parameter int ARCH_WIDTH = 64,
    parameter int STRB_WIDTH = ARCH_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic                  req_unsigned,
    input  logic [2:0]            req_width,
    input  logic [ARCH_WIDTH-1:0] req_addr,
    input  logic [ARCH_WIDTH-1:0] req_wdata,
    input  logic [4:0]            req_rd,
    input  logic                  flush,
    lsu_mem_stage_if.master       mem,
    output logic                  wb_valid,
    output logic                  wb_we,
    output logic [4:0]            wb_rd,
    output logic [ARCH_WIDTH-1:0] wb_data,
    output logic                  err_valid,
    output logic [ARCH_WIDTH-1:0] err_addr
);
    // Width codes shared with the ALU.
    localparam logic [2:0] W8  = 3'd0;
    localparam logic [2:0] W16 = 3'd1;
    localparam logic [2:0] W32 = 3'd2;
    localparam logic [2:0] W64 = 3'd3;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR} state_t;
    state_t state_q, state_d;

    logic                  is_store_q, unsigned_q, flushed_q;
    logic [2:0]            width_q;
    logic [ARCH_WIDTH-1:0] addr_q, wdata_q;
    logic [4:0]            rd_q;
    logic [ARCH_WIDTH-1:0] wb_data_q, err_addr_q;
    logic [4:0]            wb_rd_q;
    logic                  wb_we_q;

    logic                  req_bad;
    logic                  accept;
    logic [5:0]            lane_shift;
    logic [7:0]            strb;
    logic [ARCH_WIDTH-1:0] rdata_shifted, load_ext;

    assign accept     = (state_q == IDLE) && req_valid && !flush;
    assign lane_shift = {addr_q[2:0], 3'b000};

    always_comb begin
        req_bad = 1'b0;
        case (req_width)
            W8:      req_bad = 1'b0;
            W16:     req_bad = req_addr[0];
            W32:     req_bad = |req_addr[1:0];
            W64:     req_bad = |req_addr[2:0];
            default: req_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = req_bad ? ERR : REQ;
            REQ: begin
                if (mem.mem_req_ready) state_d = WAIT;
                else if (flush)        state_d = IDLE;
            end
            WAIT: if (mem.mem_resp_valid) state_d = (flushed_q || flush) ? IDLE : DONE;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        strb = 8'h00;
        case (width_q)
            W8:      strb = 8'h01 << addr_q[2:0];
            W16:     strb = 8'h03 << addr_q[2:0];
            W32:     strb = 8'h0F << addr_q[2:0];
            default: strb = 8'hFF;
        endcase
    end

    always_comb begin
        rdata_shifted = mem.mem_rdata >> lane_shift;
        case (width_q)
            W8:  load_ext = unsigned_q ? {{(ARCH_WIDTH-8){1'b0}}, rdata_shifted[7:0]}
                                       : {{(ARCH_WIDTH-8){rdata_shifted[7]}}, rdata_shifted[7:0]};
            W16: load_ext = unsigned_q ? {{(ARCH_WIDTH-16){1'b0}}, rdata_shifted[15:0]}
                                       : {{(ARCH_WIDTH-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
            W32: load_ext = unsigned_q ? {{(ARCH_WIDTH-32){1'b0}}, rdata_shifted[31:0]}
                                       : {{(ARCH_WIDTH-32){rdata_shifted[31]}}, rdata_shifted[31:0]};
            default: load_ext = rdata_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_store_q <= 1'b0;
            unsigned_q <= 1'b0;
            flushed_q  <= 1'b0;
            width_q    <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 5'd0;
            wb_data_q  <= '0;
            wb_rd_q    <= 5'd0;
            wb_we_q    <= 1'b0;
            err_addr_q <= '0;
        end else begin
            if (accept) begin
                is_store_q <= req_is_store;
                unsigned_q <= req_unsigned;
                width_q    <= req_width;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                rd_q       <= req_rd;
                flushed_q  <= 1'b0;
                if (req_bad) err_addr_q <= req_addr;
            end
            // A flush once the request is on the bus only marks the op; the response must still drain.
            if ((state_q == REQ && mem.mem_req_ready && flush) || (state_q == WAIT && flush))
                flushed_q <= 1'b1;
            if (state_q == WAIT && mem.mem_resp_valid && !flushed_q && !flush) begin
                wb_data_q <= is_store_q ? '0 : load_ext;
                wb_we_q   <= !is_store_q;
                wb_rd_q   <= rd_q;
            end
        end
    end

    assign req_ready         = (state_q == IDLE);
    assign mem.mem_req_valid = (state_q == REQ);
    assign mem.mem_we        = (state_q == REQ) && is_store_q;
    assign mem.mem_addr      = {addr_q[ARCH_WIDTH-1:3], 3'b000};
    assign mem.mem_wdata     = wdata_q << lane_shift;
    assign mem.mem_wstrb     = ((state_q == REQ) && is_store_q) ? STRB_WIDTH'(strb) : '0;

    assign wb_valid  = (state_q == DONE);
    assign wb_we     = wb_we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign err_valid = (state_q == ERR);
    assign err_addr  = err_addr_q;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - directed self-checking bench for lsu_mem_stage
module tb_lsu_mem_stage;
    localparam logic [2:0] W8  = 3'd0;
    localparam logic [2:0] W16 = 3'd1;
    localparam logic [2:0] W32 = 3'd2;
    localparam logic [2:0] W64 = 3'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_is_store = 1'b0, req_unsigned = 1'b0, flush = 1'b0;
    logic [2:0]  req_width = 3'd0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic [4:0]  req_rd = 5'd0;
    logic        req_ready, wb_valid, wb_we, err_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data, err_addr;

    int checks = 0;
    int errors = 0;

    lsu_mem_stage_if #(.ARCH_WIDTH(64)) mem_if ();

    lsu_mem_stage #(.ARCH_WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_unsigned(req_unsigned), .req_width(req_width), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd), .flush(flush),
        .mem(mem_if.master),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .err_valid(err_valid), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic present(input logic st, input logic uns, input logic [2:0] w,
                           input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd);
        req_valid = 1'b1; req_is_store = st; req_unsigned = uns; req_width = w;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
    endtask

    // Full op with a tb-driven memory: accept, stall, handshake, one-cycle response, writeback.
    task automatic mem_op(input string tag, input logic st, input logic uns, input logic [2:0] w,
                          input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                          input logic [63:0] rdata, input int stall,
                          input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
                          input logic [7:0] exp_wstrb, input logic [63:0] exp_wb);
        check({tag, ".ready_in"}, 64'(req_ready), 64'd1);
        present(st, uns, w, addr, wdata, rd);
        step();
        req_valid = 1'b0;
        check({tag, ".mem_req_valid"}, 64'(mem_if.mem_req_valid), 64'd1);
        check({tag, ".mem_addr"}, mem_if.mem_addr, exp_addr);
        check({tag, ".mem_we"}, 64'(mem_if.mem_we), 64'(st));
        check({tag, ".mem_wdata"}, mem_if.mem_wdata, exp_wdata);
        check({tag, ".mem_wstrb"}, 64'(mem_if.mem_wstrb), 64'(exp_wstrb));
        for (int i = 0; i < stall; i++) begin
            step();
            check({tag, ".stall_stable"},
                  {mem_if.mem_req_valid, mem_if.mem_we, mem_if.mem_wstrb, mem_if.mem_addr[53:0]},
                  {1'b1, st, exp_wstrb, exp_addr[53:0]});
            check({tag, ".stall_wdata"}, mem_if.mem_wdata, exp_wdata);
        end
        mem_if.mem_req_ready = 1'b1;
        step();
        mem_if.mem_req_ready = 1'b0;
        check({tag, ".wait_no_req"}, 64'(mem_if.mem_req_valid), 64'd0);
        mem_if.mem_resp_valid = 1'b1;
        mem_if.mem_rdata = rdata;
        step();
        mem_if.mem_resp_valid = 1'b0;
        check({tag, ".wb_valid"}, 64'(wb_valid), 64'd1);
        check({tag, ".wb_we"}, 64'(wb_we), 64'(!st));
        check({tag, ".wb_rd"}, 64'(wb_rd), 64'(rd));
        check({tag, ".wb_data"}, wb_data, exp_wb);
        step();
        check({tag, ".wb_pulse_end"}, 64'(wb_valid), 64'd0);
        check({tag, ".ready_back"}, 64'(req_ready), 64'd1);
        check({tag, ".wb_data_hold"}, wb_data, exp_wb);
    endtask

    initial begin
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_resp_valid = 1'b0;
        mem_if.mem_rdata = '0;
        step();
        check("reset.req_ready", 64'(req_ready), 64'd1);
        check("reset.mem_req_valid", 64'(mem_if.mem_req_valid), 64'd0);
        check("reset.wb_valid", 64'(wb_valid), 64'd0);
        check("reset.err_valid", 64'(err_valid), 64'd0);
        rst_n = 1'b1;
        step();

        // LB sign-extend, single-cycle memory (wb_valid at accept+3)
        mem_op("lb", 1'b0, 1'b0, W8, 64'h1003, 64'h0, 5'd3, 64'h0000_0000_8000_0000, 0,
               64'h1000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80);
        mem_op("lwu", 1'b0, 1'b1, W32, 64'h2004, 64'h0, 5'd4, 64'hDEAD_BEEF_0000_0000, 0,
               64'h2000, 64'h0, 8'h00, 64'h0000_0000_DEAD_BEEF);
        mem_op("lw", 1'b0, 1'b0, W32, 64'h2004, 64'h0, 5'd5, 64'hDEAD_BEEF_0000_0000, 0,
               64'h2000, 64'h0, 8'h00, 64'hFFFF_FFFF_DEAD_BEEF);
        mem_op("sh", 1'b1, 1'b0, W16, 64'h3006, 64'hABCD, 5'd6, 64'h1234, 3,
               64'h3000, 64'hABCD_0000_0000_0000, 8'hC0, 64'h0);
        mem_op("sd", 1'b1, 1'b0, W64, 64'h5008, 64'h1122_3344_5566_7788, 5'd7, 64'h0, 1,
               64'h5008, 64'h1122_3344_5566_7788, 8'hFF, 64'h0);
        mem_op("lh", 1'b0, 1'b0, W16, 64'h6002, 64'h0, 5'd8, 64'h0000_0000_8001_0000, 0,
               64'h6000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_8001);
        mem_op("ld", 1'b0, 1'b0, W64, 64'h6008, 64'h0, 5'd9, 64'h8877_6655_4433_2211, 2,
               64'h6008, 64'h0, 8'h00, 64'h8877_6655_4433_2211);

        // Misaligned SW
        present(1'b1, 1'b0, W32, 64'h4002, 64'h55, 5'd10);
        step();
        req_valid = 1'b0;
        check("sw_mis.err_valid", 64'(err_valid), 64'd1);
        check("sw_mis.err_addr", err_addr, 64'h4002);
        check("sw_mis.no_req", 64'(mem_if.mem_req_valid), 64'd0);
        check("sw_mis.wb_valid", 64'(wb_valid), 64'd0);
        step();
        check("sw_mis.err_end", 64'(err_valid), 64'd0);
        check("sw_mis.ready", 64'(req_ready), 64'd1);
        check("sw_mis.no_req2", 64'(mem_if.mem_req_valid), 64'd0);
        check("sw_mis.err_hold", err_addr, 64'h4002);

        // Illegal width code
        present(1'b0, 1'b0, 3'b111, 64'h4000, 64'h0, 5'd11);
        step();
        req_valid = 1'b0;
        check("w111.err_valid", 64'(err_valid), 64'd1);
        check("w111.err_addr", err_addr, 64'h4000);
        step();

        // req_valid together with flush in IDLE is ignored
        present(1'b0, 1'b0, W64, 64'h5000, 64'h0, 5'd12);
        flush = 1'b1;
        step();
        req_valid = 1'b0; flush = 1'b0;
        check("idle_flush.ready", 64'(req_ready), 64'd1);
        check("idle_flush.no_req", 64'(mem_if.mem_req_valid), 64'd0);

        // Flush in WAIT: response drained, no writeback
        present(1'b0, 1'b0, W64, 64'h5000, 64'h0, 5'd13);
        step();
        req_valid = 1'b0;
        mem_if.mem_req_ready = 1'b1;
        step();
        mem_if.mem_req_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("wait_flush.busy", 64'(req_ready), 64'd0);
        mem_if.mem_resp_valid = 1'b1;
        mem_if.mem_rdata = 64'hFFFF_0000_FFFF_0000;
        step();
        mem_if.mem_resp_valid = 1'b0;
        check("wait_flush.no_wb", 64'(wb_valid), 64'd0);
        check("wait_flush.ready", 64'(req_ready), 64'd1);
        check("wait_flush.wb_data_hold", wb_data, 64'h8877_6655_4433_2211);

        // Flush in REQ before the handshake
        present(1'b0, 1'b0, W64, 64'h5000, 64'h0, 5'd14);
        step();
        req_valid = 1'b0;
        check("req_flush.req_valid", 64'(mem_if.mem_req_valid), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("req_flush.dropped", 64'(mem_if.mem_req_valid), 64'd0);
        check("req_flush.ready", 64'(req_ready), 64'd1);
        step();
        check("req_flush.no_wb", 64'(wb_valid), 64'd0);

        mem_op("lbu", 1'b0, 1'b1, W8, 64'h7007, 64'h0, 5'd15, 64'hF000_0000_0000_0000, 0,
               64'h7000, 64'h0, 8'h00, 64'h0000_0000_0000_00F0);

        // Reset while in WAIT; late response must be ignored
        present(1'b0, 1'b0, W64, 64'h1000, 64'h0, 5'd16);
        step();
        req_valid = 1'b0;
        mem_if.mem_req_ready = 1'b1;
        step();
        mem_if.mem_req_ready = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        mem_if.mem_resp_valid = 1'b1;
        mem_if.mem_rdata = 64'h1234_5678_9ABC_DEF0;
        step();
        mem_if.mem_resp_valid = 1'b0;
        check("rst_wait.wb_valid", 64'(wb_valid), 64'd0);
        check("rst_wait.req_ready", 64'(req_ready), 64'd1);
        check("rst_wait.mem_req_valid", 64'(mem_if.mem_req_valid), 64'd0);
        check("rst_wait.mem_addr", mem_if.mem_addr, 64'h0);
        check("rst_wait.mem_wdata", mem_if.mem_wdata, 64'h0);
        check("rst_wait.mem_wstrb", 64'(mem_if.mem_wstrb), 64'h0);
        check("rst_wait.mem_we", 64'(mem_if.mem_we), 64'h0);
        check("rst_wait.wb_data", wb_data, 64'h0);
        check("rst_wait.wb_we", 64'(wb_we), 64'h0);
        check("rst_wait.wb_rd", 64'(wb_rd), 64'h0);
        check("rst_wait.err", {63'h0, err_valid} | err_addr, 64'h0);
        step();
        check("rst_wait.still_idle", 64'(wb_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
